// File: rtl/pc_sequencer.sv
// Program-counter unit: holds the architectural PC, offers it to fetch over
// valid/ready, and computes the next PC from the execute-stage selection.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_BOOT  | first cycle out of reset, nothing offered to fetch yet
// ST_ISSUE | pc_out offered to fetch, held until pc_ready
// ST_WAIT  | fetch accepted, waiting for execute to resolve the next PC
// ST_TRAP  | misaligned target seen, PC parked at TRAP_VECTOR
module pc_sequencer #(
    parameter int              XLEN         = 32,
    parameter int              IALIGN       = 4,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      pc_sel,
    input  logic            sel_valid,
    input  logic [XLEN-1:0] alu_in,
    input  logic [XLEN-1:0] imm_in,
    input  logic            pc_ready,
    input  logic            trap_clear,
    output logic [XLEN-1:0] pc_out,
    output logic            pc_valid,
    output logic [XLEN-1:0] link_out,
    output logic            misalign,
    output logic [XLEN-1:0] bad_addr,
    output logic [31:0]     fetch_count
);

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_TRAP  = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] bad_q, bad_d;
    logic [31:0]     count_q, count_d;
    logic            valid_q, misalign_q;
    logic [XLEN-1:0] link;
    logic [XLEN-1:0] target;
    logic            aligned;

    assign link = pc_q + XLEN'(4);

    // Reserved select value 3 falls through to the sequential PC+4 path.
    always_comb begin
        case (pc_sel)
            2'd1:    target = alu_in & ~XLEN'(1);
            2'd2:    target = pc_q + imm_in;
            default: target = link;
        endcase
    end

    assign aligned = (IALIGN == 2) ? ~target[0] : (target[1:0] == 2'b00);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        bad_d   = bad_q;
        count_d = count_q;
        case (state_q)
            ST_BOOT: state_d = ST_ISSUE;
            ST_ISSUE: begin
                if (pc_ready) begin
                    state_d = ST_WAIT;
                    count_d = count_q + 32'd1;
                end
            end
            ST_WAIT: begin
                if (sel_valid) begin
                    if (aligned) begin
                        pc_d    = target;
                        state_d = ST_ISSUE;
                    end else begin
                        bad_d   = target;
                        pc_d    = TRAP_VECTOR;
                        state_d = ST_TRAP;
                    end
                end
            end
            ST_TRAP: begin
                if (trap_clear) begin
                    pc_d    = TRAP_VECTOR;
                    state_d = ST_ISSUE;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    // pc_valid and misalign are registered from the next state so they
    // change on the same edge as the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_VECTOR;
            bad_q      <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            bad_q      <= bad_d;
            count_q    <= count_d;
            valid_q    <= (state_d == ST_ISSUE);
            misalign_q <= (state_d == ST_TRAP);
        end
    end

    assign pc_out      = pc_q;
    assign pc_valid    = valid_q;
    assign link_out    = link;
    assign misalign    = misalign_q;
    assign bad_addr    = bad_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: two instances (IALIGN=4 and IALIGN=2) share stimulus
// and are checked against an abstract PC/trap/count model.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  pc_sel = 2'd0;
    logic        sel_valid = 1'b0;
    logic        pc_ready = 1'b0;
    logic        trap_clear = 1'b0;
    logic [31:0] alu_in = '0;
    logic [31:0] imm_in = '0;

    logic [31:0] pc_out [2];
    logic [31:0] link_out [2];
    logic [31:0] bad_addr [2];
    logic [31:0] fetch_count [2];
    logic        pc_valid [2];
    logic        misalign [2];

    int n_cmp = 0;
    int n_err = 0;

    // Model: index 0 is the IALIGN=4 instance, index 1 the IALIGN=2 instance.
    logic [31:0] m_pc [2];
    logic [31:0] m_bad [2];
    logic [31:0] m_cnt [2];
    logic        m_valid [2];
    logic        m_trap [2];

    always #5 clk = ~clk;

    pc_sequencer #(.XLEN(32), .IALIGN(4)) dut4 (
        .clk(clk), .rst(rst), .pc_sel(pc_sel), .sel_valid(sel_valid),
        .alu_in(alu_in), .imm_in(imm_in), .pc_ready(pc_ready), .trap_clear(trap_clear),
        .pc_out(pc_out[0]), .pc_valid(pc_valid[0]), .link_out(link_out[0]),
        .misalign(misalign[0]), .bad_addr(bad_addr[0]), .fetch_count(fetch_count[0])
    );

    pc_sequencer #(.XLEN(32), .IALIGN(2)) dut2 (
        .clk(clk), .rst(rst), .pc_sel(pc_sel), .sel_valid(sel_valid),
        .alu_in(alu_in), .imm_in(imm_in), .pc_ready(pc_ready), .trap_clear(trap_clear),
        .pc_out(pc_out[1]), .pc_valid(pc_valid[1]), .link_out(link_out[1]),
        .misalign(misalign[1]), .bad_addr(bad_addr[1]), .fetch_count(fetch_count[1])
    );

    function automatic logic [129:0] observed(int i);
        return {pc_out[i], link_out[i], bad_addr[i], fetch_count[i], pc_valid[i], misalign[i]};
    endfunction

    function automatic logic [129:0] expected(int i);
        logic [31:0] link;
        link = m_pc[i] + 32'd4;
        return {m_pc[i], link, m_bad[i], m_cnt[i], m_valid[i], m_trap[i]};
    endfunction

    function automatic logic [31:0] model_target(logic [31:0] pc, logic [1:0] sel,
                                                 logic [31:0] alu, logic [31:0] imm);
        if (sel == 2'd1) return alu - (alu % 2);
        if (sel == 2'd2) return pc + imm;
        return pc + 32'd4;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_pc[i] = 32'h0; m_bad[i] = '0; m_cnt[i] = '0;
            m_valid[i] = 1'b0; m_trap[i] = 1'b0;
        end
    endtask

    task automatic test_reset();
        model_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (observed(i) !== expected(i)) begin
                n_err++;
                $display("FAIL reset_hold dut%0d got %h want %h", i, observed(i), expected(i));
            end
        end
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) m_valid[i] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (observed(i) !== expected(i)) begin
                n_err++;
                $display("FAIL boot_to_issue dut%0d got %h want %h", i, observed(i), expected(i));
            end
        end
        repeat (5) begin
            sel_valid = 1'($urandom);
            trap_clear = 1'($urandom);
            @(negedge clk);
        end
        sel_valid = 1'b0;
        trap_clear = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (observed(i) !== expected(i)) begin
                n_err++;
                $display("FAIL issue_stall dut%0d got %h want %h", i, observed(i), expected(i));
            end
        end
    endtask

    // One full loop: optional stall in ISSUE, accept, optional idle in WAIT,
    // resolve the next PC, and clear any trap that results.
    task automatic do_fetch(input logic [1:0] sel, input logic [31:0] alu,
                            input logic [31:0] imm, input int stall);
        logic [31:0] t;
        bit bad;
        repeat (stall) begin
            pc_ready = 1'b0;
            sel_valid = 1'($urandom);
            trap_clear = 1'($urandom);
            @(negedge clk);
        end
        sel_valid = 1'b0;
        trap_clear = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (observed(i) !== expected(i)) begin
                n_err++;
                $display("FAIL offer dut%0d got %h want %h", i, observed(i), expected(i));
            end
        end
        pc_ready = 1'b1;
        @(negedge clk);
        pc_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = m_cnt[i] + 32'd1;
            m_valid[i] = 1'b0;
        end
        repeat (stall) begin
            pc_ready = 1'($urandom);
            trap_clear = 1'($urandom);
            @(negedge clk);
        end
        pc_ready = 1'b0;
        trap_clear = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (observed(i) !== expected(i)) begin
                n_err++;
                $display("FAIL accepted dut%0d got %h want %h", i, observed(i), expected(i));
            end
        end
        pc_sel = sel; alu_in = alu; imm_in = imm; sel_valid = 1'b1;
        @(negedge clk);
        sel_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            t = model_target(m_pc[i], sel, alu, imm);
            bad = (i == 0) ? (t % 4 != 0) : (t % 2 != 0);
            if (bad) begin
                m_bad[i] = t; m_pc[i] = 32'h100; m_trap[i] = 1'b1; m_valid[i] = 1'b0;
            end else begin
                m_pc[i] = t; m_valid[i] = 1'b1;
            end
        end
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (observed(i) !== expected(i)) begin
                n_err++;
                $display("FAIL resolve dut%0d sel=%0d got %h want %h", i, sel, observed(i), expected(i));
            end
        end
        if (m_trap[0] || m_trap[1]) begin
            trap_clear = 1'b1;
            @(negedge clk);
            trap_clear = 1'b0;
            for (int i = 0; i < 2; i++) begin
                m_trap[i] = 1'b0; m_valid[i] = 1'b1;
            end
            for (int i = 0; i < 2; i++) begin
                n_cmp++;
                if (observed(i) !== expected(i)) begin
                    n_err++;
                    $display("FAIL trap_clear dut%0d got %h want %h", i, observed(i), expected(i));
                end
            end
        end
    endtask

    task automatic test_sequential();
        do_fetch(2'd1, 32'h10, 32'h0, 0);
        do_fetch(2'd0, 32'h0, 32'h0, 1);
        n_cmp++;
        if (pc_out[0] !== 32'h14 || link_out[0] !== 32'h18) begin
            n_err++;
            $display("FAIL seq_plus4 got pc=%h link=%h want pc=00000014 link=00000018", pc_out[0], link_out[0]);
        end
        do_fetch(2'd3, 32'hDEAD_BEEF, 32'h1234_5678, 0);
        n_cmp++;
        if (pc_out[0] !== 32'h18) begin
            n_err++;
            $display("FAIL seq_reserved got %h want 00000018", pc_out[0]);
        end
    endtask

    task automatic test_jump_branch();
        do_fetch(2'd1, 32'h20, 32'h0, 0);
        do_fetch(2'd1, 32'h41, 32'h0, 2);
        n_cmp++;
        if (pc_out[0] !== 32'h40) begin
            n_err++;
            $display("FAIL jump_alu got %h want 00000040", pc_out[0]);
        end
        do_fetch(2'd2, 32'h0, 32'hFFFF_FFF0, 0);
        n_cmp++;
        if (pc_out[0] !== 32'h30) begin
            n_err++;
            $display("FAIL branch_imm got %h want 00000030", pc_out[0]);
        end
    endtask

    task automatic test_misalign();
        do_fetch(2'd2, 32'h0, 32'h6, 0);
        n_cmp++;
        if (pc_out[0] !== 32'h100 || bad_addr[0] !== 32'h36 || pc_valid[0] !== 1'b1) begin
            n_err++;
            $display("FAIL trap_ialign4 got pc=%h bad=%h valid=%b want 00000100 00000036 1",
                     pc_out[0], bad_addr[0], pc_valid[0]);
        end
        n_cmp++;
        if (pc_out[1] !== 32'h36 || misalign[1] !== 1'b0) begin
            n_err++;
            $display("FAIL no_trap_ialign2 got pc=%h mis=%b want 00000036 0", pc_out[1], misalign[1]);
        end
    endtask

    task automatic test_wrap();
        do_fetch(2'd1, 32'hFFFF_FFFC, 32'h0, 0);
        n_cmp++;
        if (link_out[0] !== 32'h0) begin
            n_err++;
            $display("FAIL link_wrap got %h want 00000000", link_out[0]);
        end
        do_fetch(2'd0, 32'h0, 32'h0, 0);
        n_cmp++;
        if (pc_out[0] !== 32'h0 || pc_out[1] !== 32'h0) begin
            n_err++;
            $display("FAIL pc_wrap got %h/%h want 00000000", pc_out[0], pc_out[1]);
        end
    endtask

    task automatic test_random();
        logic [31:0] imm;
        for (int k = 0; k < 40; k++) begin
            imm = $urandom;
            if ($urandom_range(0, 1) == 0) imm = imm & 32'hFFFF_FFFC;
            do_fetch(2'($urandom_range(0, 3)), $urandom, imm, $urandom_range(0, 3));
        end
    endtask

    task automatic test_reset_mid();
        pc_ready = 1'b1;
        @(negedge clk);
        pc_ready = 1'b0;
        #2 rst = 1'b1;
        model_reset();
        #1;
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (observed(i) !== expected(i)) begin
                n_err++;
                $display("FAIL rst_mid_wait dut%0d got %h want %h", i, observed(i), expected(i));
            end
        end
        @(negedge clk);
        pc_sel = 2'd1; alu_in = 32'h80; sel_valid = 1'b1; trap_clear = 1'b1; pc_ready = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (observed(i) !== expected(i)) begin
                n_err++;
                $display("FAIL rst_ignores_inputs dut%0d got %h want %h", i, observed(i), expected(i));
            end
        end
        sel_valid = 1'b0; trap_clear = 1'b0; pc_ready = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) m_valid[i] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (observed(i) !== expected(i)) begin
                n_err++;
                $display("FAIL restart_after_wait dut%0d got %h want %h", i, observed(i), expected(i));
            end
        end

        do_fetch(2'd1, 32'h200, 32'h0, 0);
        pc_ready = 1'b1;
        @(negedge clk);
        pc_ready = 1'b0;
        pc_sel = 2'd2; imm_in = 32'h2; sel_valid = 1'b1;
        @(negedge clk);
        sel_valid = 1'b0;
        for (int i = 0; i < 2; i++) m_cnt[i] = m_cnt[i] + 32'd1;
        m_bad[0] = 32'h202; m_pc[0] = 32'h100; m_trap[0] = 1'b1; m_valid[0] = 1'b0;
        m_pc[1] = 32'h202; m_valid[1] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (observed(i) !== expected(i)) begin
                n_err++;
                $display("FAIL trap_entry dut%0d got %h want %h", i, observed(i), expected(i));
            end
        end
        #3 rst = 1'b1;
        model_reset();
        #1;
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (observed(i) !== expected(i)) begin
                n_err++;
                $display("FAIL rst_mid_trap dut%0d got %h want %h", i, observed(i), expected(i));
            end
        end
        @(negedge clk);
        trap_clear = 1'b1; sel_valid = 1'b1; pc_ready = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (observed(i) !== expected(i)) begin
                n_err++;
                $display("FAIL rst_trap_ignores dut%0d got %h want %h", i, observed(i), expected(i));
            end
        end
        trap_clear = 1'b0; sel_valid = 1'b0; pc_ready = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) m_valid[i] = 1'b1;
        do_fetch(2'd0, 32'h0, 32'h0, 1);
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_jump_branch();
        test_misalign();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
